// File: rtl/vga_theme_palette_pkg.sv
// vga_theme_pkg: shared theme/class codes, widths, fixed palettes and lookup helper
package vga_theme_pkg;
  localparam int CLS_W = 2;
  localparam int COLOR_W = 12;
  typedef enum logic [1:0] {
    THEME_DARK   = 2'b00,
    THEME_BRIGHT = 2'b01,
    THEME_CUSTOM = 2'b10,
    THEME_RSVD   = 2'b11
  } theme_e;
  typedef enum logic [CLS_W-1:0] {
    CLS_BG        = 2'd0,
    CLS_FG        = 2'd1,
    CLS_ACCENT    = 2'd2,
    CLS_HIGHLIGHT = 2'd3
  } cls_e;
  typedef logic [3:0][COLOR_W-1:0] palette_t;
  // Element 0 is the background class, element 3 the highlight class.
  localparam palette_t DARK_PAL   = {12'hFF0, 12'h0AF, 12'hFFF, 12'h000};
  localparam palette_t BRIGHT_PAL = {12'hF80, 12'h05A, 12'h000, 12'hFFF};
  // Colour for a class under an applied theme; the reserved code never reaches here.
  function automatic logic [COLOR_W-1:0] pal_lookup(logic [1:0] th, logic [CLS_W-1:0] c, palette_t live);
    return th == THEME_BRIGHT ? BRIGHT_PAL[c] : th == THEME_CUSTOM ? live[c] : DARK_PAL[c];
  endfunction
endpackage

// File: rtl/vga_theme_palette_if.sv
// vga_theme_palette_if: custom-palette configuration bus
interface vga_theme_palette_if;
  import vga_theme_pkg::*;
  logic               cfg_we;
  logic [CLS_W-1:0]   cfg_addr;
  logic [COLOR_W-1:0] cfg_data;
  logic               cfg_ack;
  modport master (output cfg_we, cfg_addr, cfg_data, input cfg_ack);
  modport slave (input cfg_we, cfg_addr, cfg_data, output cfg_ack);
endinterface

// File: rtl/vga_palette_regs.sv
// vga_palette_regs: double-buffered custom palette, shadow written any time, live swapped on commit
module vga_palette_regs
  import vga_theme_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [CLS_W-1:0]   addr_i,
  input  logic [COLOR_W-1:0] data_i,
  input  logic               commit_i,
  output palette_t           live_o
);
  palette_t shadow_q, live_q;
  // Commit copies the pre-write shadow, so a coincident write lands one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DARK_PAL;
      live_q   <= DARK_PAL;
    end else begin
      if (we_i) shadow_q[addr_i] <= data_i;
      if (commit_i) live_q <= shadow_q;
    end
  end
  assign live_o = live_q;
endmodule

// File: rtl/vga_theme_palette.sv
// vga_theme_palette: frame-synchronous theme latch and 2-cycle class-to-RGB pipeline
module vga_theme_palette
  import vga_theme_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          theme,
  input  logic                vsync_start,
  input  logic                valid_in,
  input  logic [CLS_W-1:0]    cls_in,
  output logic                valid_out,
  output logic [COLOR_W-1:0]  rgb_out,
  output logic [1:0]          active_theme,
  output logic                theme_changed,
  vga_theme_palette_if.slave  cfg
);
  logic [1:0]         active_q, active_d;
  logic               changed_q, v1_q, vout_q, ack_q;
  logic [CLS_W-1:0]   cls1_q;
  logic [COLOR_W-1:0] rgb_q;
  palette_t           live;
  vga_palette_regs u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (cfg.cfg_we),
    .addr_i   (cfg.cfg_addr),
    .data_i   (cfg.cfg_data),
    .commit_i (vsync_start),
    .live_o   (live)
  );
  assign active_d = vsync_start ? (theme == THEME_RSVD ? THEME_DARK : theme) : active_q;
  // Theme latch at frame start, with a pulse only when the applied theme actually moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= THEME_DARK;
      changed_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      changed_q <= active_d != active_q;
    end
  end
  // Stage 1 captures the pixel, stage 2 registers its colour (zero when no pixel).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      cls1_q <= '0;
      vout_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      v1_q   <= valid_in;
      cls1_q <= cls_in;
      vout_q <= v1_q;
      rgb_q  <= v1_q ? pal_lookup(active_q, cls1_q, live) : '0;
    end
  end
  // Every configuration write is accepted and acknowledged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else ack_q <= cfg.cfg_we;
  end
  assign valid_out     = vout_q;
  assign rgb_out       = rgb_q;
  assign active_theme  = active_q;
  assign theme_changed = changed_q;
  assign cfg.cfg_ack   = ack_q;
endmodule

// File: tb/tb_vga_theme_palette.sv
// tb_vga_theme_palette: directed vector table plus randomized run against a frame-level palette model
module tb_vga_theme_palette;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  theme = '0;
  logic        vsync_start = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  cls_in = '0;
  logic        valid_out, theme_changed;
  logic [11:0] rgb_out;
  logic [1:0]  active_theme;
  vga_theme_palette_if cif ();
  always #5 clk = ~clk;
  vga_theme_palette dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .theme         (theme),
    .vsync_start   (vsync_start),
    .valid_in      (valid_in),
    .cls_in        (cls_in),
    .valid_out     (valid_out),
    .rgb_out       (rgb_out),
    .active_theme  (active_theme),
    .theme_changed (theme_changed),
    .cfg           (cif)
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] dark_c[4]   = '{12'h000, 12'hFFF, 12'h0AF, 12'hFF0};
  logic [11:0] bright_c[4] = '{12'hFFF, 12'h000, 12'h05A, 12'hF80};
  logic [11:0] m_shadow[4], m_live[4];
  logic [1:0]  m_theme, p_cls;
  logic        p_v;
  logic        e_v, e_chg, e_ack;
  logic [11:0] e_rgb;
  typedef struct {
    int th, vs, v, c, we, a, d;
    int ev, er, et, ec, ea;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int th, int vs, int v, int c, int we, int a, int d,
                              int ev, int er, int et, int ec, int ea);
    vec_t r;
    r.th = th; r.vs = vs; r.v = v; r.c = c; r.we = we; r.a = a; r.d = d;
    r.ev = ev; r.er = er; r.et = et; r.ec = ec; r.ea = ea;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [11:0] color(logic [1:0] th, logic [1:0] c);
    return th == 2'd1 ? bright_c[c] : th == 2'd2 ? m_live[c] : dark_c[c];
  endfunction
  task automatic m_reset();
    m_shadow = dark_c;
    m_live = dark_c;
    m_theme = 2'd0;
    p_v = 1'b0;
    p_cls = 2'd0;
  endtask
  task automatic cycle(int th, int vs, int v, int c, int we, int a, int d);
    logic [1:0] nt;
    @(negedge clk);
    theme = 2'(th); vsync_start = 1'(vs); valid_in = 1'(v); cls_in = 2'(c);
    cif.cfg_we = 1'(we); cif.cfg_addr = 2'(a); cif.cfg_data = 12'(d);
    @(posedge clk);
    e_v = p_v;
    e_rgb = p_v ? color(m_theme, p_cls) : 12'h000;
    e_ack = 1'(we);
    nt = (th == 3) ? 2'd0 : 2'(th);
    e_chg = (vs != 0) && (nt != m_theme);
    if (vs != 0) begin
      m_live = m_shadow;
      m_theme = nt;
    end
    if (we != 0) m_shadow[a] = 12'(d);
    p_v = 1'(v);
    p_cls = 2'(c);
    #1;
    chk("model_valid_out", 32'(valid_out), 32'(e_v));
    chk("model_rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("model_active_theme", 32'(active_theme), 32'(m_theme));
    chk("model_theme_changed", 32'(theme_changed), 32'(e_chg));
    chk("model_cfg_ack", 32'(cif.cfg_ack), 32'(e_ack));
  endtask
  initial begin
    cif.cfg_we = 1'b0; cif.cfg_addr = '0; cif.cfg_data = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_rgb_out", 32'(rgb_out), 32'd0);
    chk("reset_active_theme", 32'(active_theme), 32'd0);
    chk("reset_theme_changed", 32'(theme_changed), 32'd0);
    chk("reset_cfg_ack", 32'(cif.cfg_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // th vs v c we a d | valid rgb theme changed ack
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,       0, 'h000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,       1, 'h000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0,       1, 'hFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0,       1, 'h0AF, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,       1, 'hFF0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,       1, 'h000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,       0, 'h000, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,       1, 'hFFF, 1, 0, 0));
    tbl.push_back(mk(3, 1, 0, 0, 0, 0, 0,       0, 'h000, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 1, 2, 'hABC,   0, 'h000, 0, 0, 1));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0,       0, 'h000, 2, 1, 0));
    tbl.push_back(mk(2, 0, 1, 2, 0, 0, 0,       0, 'h000, 2, 0, 0));
    tbl.push_back(mk(2, 0, 1, 0, 0, 0, 0,       1, 'hABC, 2, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0,       1, 'h000, 2, 0, 0));
    tbl.push_back(mk(2, 1, 0, 0, 1, 1, 'h123,   1, 'hFFF, 2, 0, 1));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0,       0, 'h000, 2, 0, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0,       1, 'hFFF, 2, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0,       0, 'h000, 2, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0,       1, 'h123, 2, 0, 0));
    foreach (tbl[i]) begin
      cycle(tbl[i].th, tbl[i].vs, tbl[i].v, tbl[i].c, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_rgb_out", i), 32'(rgb_out), 32'(tbl[i].er));
      chk($sformatf("vec%0d_active_theme", i), 32'(active_theme), 32'(tbl[i].et));
      chk($sformatf("vec%0d_theme_changed", i), 32'(theme_changed), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_cfg_ack", i), 32'(cif.cfg_ack), 32'(tbl[i].ea));
    end
    cycle(2, 0, 1, 2, 0, 0, 0);
    cycle(2, 0, 1, 2, 0, 0, 0);
    chk("pre_reset_rgb_custom", 32'(rgb_out), 32'h0ABC);
    @(negedge clk);
    rst_n = 1'b0;
    theme = '0; vsync_start = 1'b0; valid_in = 1'b0; cls_in = '0; cif.cfg_we = 1'b0;
    #1;
    chk("async_reset_valid_out", 32'(valid_out), 32'd0);
    chk("async_reset_rgb_out", 32'(rgb_out), 32'd0);
    chk("async_reset_active_theme", 32'(active_theme), 32'd0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 1, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_accent_dark", 32'(rgb_out), 32'h00AF);
    for (int i = 0; i < 3000; i++) begin
      cycle(int'($urandom_range(0, 3)), int'($urandom_range(0, 11) == 0), int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4095)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_theme_palette.md
# vga_theme_palette

Pixel-class-to-RGB palette stage for the VGA output path. It consumes the 2-bit `theme` code produced by the theme controller and a per-pixel colour class from the renderer, and emits 12-bit RGB after a fixed 2-cycle pipeline. Theme changes and custom-palette updates take effect only at frame boundaries, so a frame is never drawn with mixed colours. It sits between the renderer and the VGA sync/output block.

## Interface
- `CLS_W`, 2, pixel class width (4 classes: 0 bg, 1 fg, 2 accent, 3 highlight)
- `COLOR_W`, 12, RGB width, 4:4:4 as {R,G,B}

- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous reset, active-low
- `theme`  in  2  requested theme: 00 dark, 01 bright, 10 custom, 11 reserved
- `vsync_start`  in  1  one-cycle pulse at start of vertical blanking
- `valid_in`  in  1  active-video pixel present
- `cls_in`  in  CLS_W  pixel colour class
- `valid_out`  out  1  `valid_in` delayed 2 cycles
- `rgb_out`  out  COLOR_W  pixel colour; 0 when `valid_out`=0
- `cfg_we`  in  1  custom-palette write strobe
- `cfg_addr`  in  CLS_W  class index to write
- `cfg_data`  in  COLOR_W  colour value
- `cfg_ack`  out  1  one-cycle pulse, cycle after an accepted `cfg_we`
- `active_theme`  out  2  theme currently applied
- `theme_changed`  out  1  one-cycle pulse when `active_theme` changes

## Operation
- Theme latch: on `vsync_start`, `active_theme` <= `theme`. Code 11 maps to 00. `theme` is ignored at all other times.
- `theme_changed` pulses in the cycle after the latch edge only if the new value differs from the old one.
- Dark palette: bg 000, fg FFF, accent 0AF, highlight FF0.
- Bright palette: bg FFF, fg 000, accent 05A, highlight F80.
- Custom palette: 4-entry double buffer.
  - `cfg_we` writes shadow[`cfg_addr`] <= `cfg_data`. Every write is accepted and answered with `cfg_ack`. Back-to-back writes are allowed, one per cycle.
  - On `vsync_start`, live <= shadow, all 4 entries at once.
  - If `cfg_we` and `vsync_start` occur in the same cycle, live takes the pre-write shadow. The new value is applied at the next `vsync_start`.
- Lookup: the colour is chosen from (`active_theme`, class) using the live palette. If the stage-1 valid is 0, the result is forced to 0.
- Reset values:
  - `active_theme`=00
  - shadow and live = dark palette values
  - `valid_out`=0, `rgb_out`=0, `cfg_ack`=0, `theme_changed`=0
  - Pipeline registers clear. Reset mid-frame drops any in-flight pixels.

## Timing
- Latency is 2 cycles.
  - Edge t samples `valid_in`/`cls_in` into stage 1.
  - Edge t+1 registers `rgb_out`/`valid_out`.
  - The lookup at edge t+1 uses `active_theme` and live registers as they stand before t+1.
- Throughput is 1 pixel per cycle with no stalls.
- After a `vsync_start` sampled at edge t, `active_theme` and live are updated after edge t, and `theme_changed` is high in cycle t..t+1.
- A pixel whose stage-1 lookup straddles the latch edge uses the new theme. The renderer never asserts `valid_in` during blanking, so this does not occur in normal operation.
- `cfg_ack` is high in the cycle after the edge that sampled `cfg_we`.

## Structure
- Package `vga_theme_pkg`:
  - theme codes `THEME_DARK`/`THEME_BRIGHT`/`THEME_CUSTOM`
  - class codes
  - `COLOR_W`
  - dark and bright palette constants
- Sub-module `vga_palette_regs`: shadow/live register file with write port, commit strobe and 4 live outputs.
- Top level contains the theme latch, change detect, lookup mux and 2-stage pipeline.

## Test plan
- Reset, then stream classes 0,1,2,3 with `valid_in`=1 -> 2 cycles later `rgb_out` = 000, FFF, 0AF, FF0; `cfg_ack`=0 and `theme_changed`=0 throughout.
- Hold `theme`=01 mid-frame -> colours stay dark. Pulse `vsync_start` -> `active_theme`=01, one `theme_changed` pulse, class 0 -> FFF. Pulse again with `theme`=01 -> no pulse.
- `theme`=11 then `vsync_start` (from 01) -> `active_theme`=00 and `theme_changed` pulses.
- Custom: write addr 2 = ABC (`cfg_ack` next cycle), set `theme`=10, pulse `vsync_start` -> class 2 -> ABC, class 0 -> 000.
- `cfg_we` (addr 1 = 123) coincident with `vsync_start` -> class 1 stays FFF this frame and becomes 123 after the next `vsync_start`.
- Deassert `rst_n` mid-stream with custom theme active -> `valid_out`/`rgb_out`=0 immediately, and after release class 2 -> 0AF under dark.
